frame_op_sequencer: RTL
=======================

# frame_op_sequencer

Job-level controller for the RGB888 image reader pipeline. Accepts a command (operation, operand, frame count) over a valid/ready handshake, launches the reader once per frame, and supervises each frame's VSYNC/HSYNC/done sequence. Checks line and frame geometry and spaces frames with a programmable gap. Sits between the host/testbench command source and the reader/writer datapath.

## Interface
- WIDTH, 100: pixels per line. Even; reader delivers 2 pixels/cycle.
- HEIGHT, 100: lines per frame.
- GAP_CYCLES, 16: idle cycles between consecutive frames of one job, ≥1.
- TIMEOUT, 65535: watchdog limit in cycles without progress (WATCHDOG_EN only).
- HCLK  in  1  single clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_op  in  2  0 pass, 1 brightness, 2 invert, 3 threshold.
- cmd_value  in  8  operand (brightness value or threshold).
- cmd_frames  in  4  frames to process; 0 treated as 1.
- rd_start  out  1  one-cycle launch pulse to reader.
- rd_op  out  2  latched operation, stable for the whole job.
- rd_value  out  8  latched operand, stable for the whole job.
- rd_vsync  in  1  reader vertical-sync level.
- rd_hsync  in  1  reader line-valid level (high while pixel pairs stream).
- rd_done  in  1  reader end-of-frame flag.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  4  frames completed in current job.
- line_cnt  out  10  lines seen in current frame.
- job_done  out  1  one-cycle pulse at job end (normal or aborted).
- err  out  1  sticky error; cleared on next command accept.
- err_code  out  2  0 none, 1 line length, 2 line count, 3 timeout; first error wins.

## Operation
- States: IDLE, START, WAIT_V, STREAM, GAP, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch op/value/frames, clear frame_cnt, line_cnt, err, err_code → START.
- START: rd_start=1 for exactly one cycle, line_cnt←0 → WAIT_V.
- WAIT_V: wait for rd_vsync=1 → STREAM. rd_hsync/rd_done ignored here.
- STREAM: line_cnt increments on each rd_hsync rising edge (saturates at 1023). Run counter counts rd_hsync-high cycles; on falling edge, run ≠ WIDTH/2 → err_code 1.
- STREAM, rd_done=1: line_cnt ≠ HEIGHT → err_code 2 (unless already set); frame_cnt+1; if frame_cnt+1 == frames → DONE else → GAP.
- rd_done coincident with hsync falling edge: line-length check evaluated first, then line-count check, same cycle.
- GAP: count GAP_CYCLES cycles → START.
- DONE: job_done=1 one cycle → IDLE.
- Geometry errors do not abort; job runs to completion with err set.
- Arithmetic: run counter 10 bits, compared against WIDTH/2; frame_cnt 4 bits, no wrap possible (max 15).

## Timing
- Reset: state IDLE, cmd_ready=1, all other outputs 0, counters 0.
- Command accept cycle N → rd_start high in cycle N+1.
- rd_done sampled in cycle M → frame_cnt updated M+1; last frame → job_done high M+1 (DONE), cmd_ready high M+2.
- Non-last frame: rd_start re-asserted GAP_CYCLES+1 cycles after rd_done sample.
- rd_op/rd_value change only at command accept.
- Reset mid-job: immediate return to IDLE, no job_done, outputs to reset values.

## Configuration
- FRAME_WATCHDOG_EN defined: counter reset on state change, hsync edge and rd_done; increments in WAIT_V and STREAM; reaching TIMEOUT sets err_code 3, err=1, → DONE (job_done pulse, remaining frames skipped).
- Undefined: no watchdog logic; sequencer waits indefinitely in WAIT_V/STREAM; err_code 3 never produced.

## Test plan
- Reset then cmd op=1 value=100 frames=1, model reader 100 lines × 50 cycles -> rd_start 1 cycle after accept, line_cnt=100, frame_cnt=1, job_done once, err=0.
- frames=3, GAP_CYCLES=16 -> exactly 3 rd_start pulses, each 17 cycles after preceding rd_done, frame_cnt=3.
- Model one line with 49 hsync cycles -> err=1, err_code=1, job still completes; next accepted command clears err.
- Model 99 lines then rd_done -> err_code=2; rd_done coincident with final hsync fall of 49-cycle line -> err_code=1 (first wins).
- FRAME_WATCHDOG_EN, TIMEOUT=200, reader never raises rd_vsync -> err_code=3 at 200 cycles after START, job_done pulse, cmd_ready returns.
- HRESETn low mid-STREAM, cmd_valid held high -> busy=0, cmd_ready=1, no job_done; new job accepted first cycle after release.

Source files
------------

// File: rtl/frame_op_sequencer.sv
// frame_op_sequencer
//
// Purpose: job-level controller for the RGB888 image reader pipeline. It accepts one
// command (operation, operand, frame count), launches the reader once per frame,
// supervises each frame's VSYNC/HSYNC/done sequence, checks line length and line count,
// and inserts a programmable idle gap between frames of the same job.
//
// Optional feature: define FRAME_WATCHDOG_EN to add a no-progress watchdog. When it
// expires, err_code 3 is flagged and the job is aborted through DONE. Without the
// macro the sequencer waits indefinitely in WAIT_V/STREAM.
//
// Parameters:
//   WIDTH      pixels per line (even, two pixels per hsync cycle)
//   HEIGHT     lines per frame
//   GAP_CYCLES idle cycles between frames of one job (>= 1)
//   TIMEOUT    watchdog limit in cycles (FRAME_WATCHDOG_EN only)
//
// Ports:
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/value/frames       command fields; frames 0 is treated as 1
//   rd_start                  one-cycle reader launch pulse
//   rd_op/rd_value            operation/operand latched at command accept
//   rd_vsync/hsync/done       reader frame status
//   busy                      any state other than IDLE
//   frame_cnt/line_cnt        frames completed in job / lines seen in frame
//   job_done                  one-cycle pulse at end of job
//   err/err_code              sticky error and first error cause

module frame_op_sequencer #(
    parameter int unsigned WIDTH      = 100,
    parameter int unsigned HEIGHT     = 100,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_value,
    input  logic [3:0] cmd_frames,
    output logic       rd_start,
    output logic [1:0] rd_op,
    output logic [7:0] rd_value,
    input  logic       rd_vsync,
    input  logic       rd_hsync,
    input  logic       rd_done,
    output logic       busy,
    output logic [3:0] frame_cnt,
    output logic [9:0] line_cnt,
    output logic       job_done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned GapW      = $clog2(GAP_CYCLES + 1);
    localparam logic [9:0]  RunTarget = 10'(WIDTH / 2);
    localparam logic [9:0]  LineTgt   = 10'(HEIGHT);
    localparam logic [9:0]  CntMax    = 10'h3FF;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitV,
        StStream,
        StGap,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      value_q, value_d;
    logic [3:0]      frames_q, frames_d;
    logic [3:0]      frame_cnt_q, frame_cnt_d;
    logic [9:0]      line_cnt_q, line_cnt_d;
    logic [9:0]      run_q, run_d;
    logic            hsync_q;
    logic [GapW-1:0] gap_q, gap_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rd_start_q, rd_start_d;
    logic            busy_q, busy_d;
    logic            job_done_q, job_done_d;
    logic [1:0]      code_v;

    logic hs_rise, hs_fall;
    assign hs_rise = rd_hsync & ~hsync_q;
    assign hs_fall = ~rd_hsync & hsync_q;

`ifdef FRAME_WATCHDOG_EN
    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WdW-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        value_d     = value_q;
        frames_d    = frames_q;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;
        run_d       = run_q;
        gap_d       = gap_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        code_v      = err_code_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    value_d     = cmd_value;
                    frames_d    = (cmd_frames == 4'd0) ? 4'd1 : cmd_frames;
                    frame_cnt_d = 4'd0;
                    line_cnt_d  = 10'd0;
                    err_d       = 1'b0;
                    err_code_d  = 2'd0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                line_cnt_d = 10'd0;
                run_d      = 10'd0;
                state_d    = StWaitV;
            end
            StWaitV: begin
                if (rd_vsync) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (hs_rise) begin
                    if (line_cnt_q != CntMax) begin
                        line_cnt_d = line_cnt_q + 10'd1;
                    end
                    run_d = 10'd1;
                end else if (rd_hsync && run_q != CntMax) begin
                    run_d = run_q + 10'd1;
                end
                // Line-length check precedes the line-count check so a short final line
                // reported together with rd_done keeps code 1.
                if (hs_fall && run_q != RunTarget) begin
                    err_d = 1'b1;
                    if (code_v == 2'd0) begin
                        code_v = 2'd1;
                    end
                end
                if (rd_done) begin
                    if (line_cnt_q != LineTgt) begin
                        err_d = 1'b1;
                        if (code_v == 2'd0) begin
                            code_v = 2'd2;
                        end
                    end
                    frame_cnt_d = frame_cnt_q + 4'd1;
                    gap_d       = '0;
                    state_d     = (frame_cnt_d == frames_q) ? StDone : StGap;
                end
                err_code_d = code_v;
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StStart;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FRAME_WATCHDOG_EN
        wd_d = wd_q;
        if (state_d != state_q || hs_rise || hs_fall || rd_done) begin
            wd_d = '0;
        end else if (state_q == StWaitV || state_q == StStream) begin
            if (wd_q + WdW'(1) == WdW'(TIMEOUT)) begin
                wd_d  = '0;
                err_d = 1'b1;
                if (err_code_d == 2'd0) begin
                    err_code_d = 2'd3;
                end
                state_d = StDone;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif

        // Status outputs are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == StIdle);
        rd_start_d  = (state_d == StStart);
        busy_d      = (state_d != StIdle);
        job_done_d  = (state_d == StDone);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            value_q     <= 8'd0;
            frames_q    <= 4'd0;
            frame_cnt_q <= 4'd0;
            line_cnt_q  <= 10'd0;
            run_q       <= 10'd0;
            hsync_q     <= 1'b0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            cmd_ready_q <= 1'b1;
            rd_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
`ifdef FRAME_WATCHDOG_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            value_q     <= value_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            run_q       <= run_d;
            hsync_q     <= rd_hsync;
            gap_q       <= gap_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_ready_q <= cmd_ready_d;
            rd_start_q  <= rd_start_d;
            busy_q      <= busy_d;
            job_done_q  <= job_done_d;
`ifdef FRAME_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rd_start  = rd_start_q;
    assign rd_op     = op_q;
    assign rd_value  = value_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign line_cnt  = line_cnt_q;
    assign job_done  = job_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
